// File: rtl/serial_add_sub_8bit_pkg.sv
// Shared definitions for the bit-serial add/sub block: control state
// encoding and the default operand width.
package serial_add_sub_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_8bit_onebitfa.sv
// One-bit full adder cell used for each serial step of the add/sub block.
module onebitfa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub_8bit.sv
// Bit-serial, LSB-first adder/subtractor. Operands are captured through a
// valid/ready handshake, processed one bit per clock through a single full
// adder, and the finished result is held behind a valid/ready output.
// Subtraction is A + ~B + 1, so carry_out = 1 means "no borrow".
module serial_add_sub_8bit
  import serial_add_sub_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             res_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_step;

  onebitfa u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_sum),
    .cout(fa_cout)
  );

  // The new result bit enters at the MSB so after WIDTH steps r_sr is LSB-aligned.
  assign r_next    = WIDTH'({fa_sum, r_sr} >> 1);
  assign last_step = (count == CNT_W'(WIDTH - 1));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept in IDLE, count through RUN, wait for consumer in DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)  state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Serial datapath; visible result registers only update on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      count     <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      res_zero  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr  <= op_a;
            b_sr  <= op_b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
          end
        end
        ST_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_next;
          carry <= fa_cout;
          count <= count + CNT_W'(1);
          if (last_step) begin
            sum       <= r_next;
            carry_out <= fa_cout;
            res_zero  <= (r_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_sub_8bit.md
Name: serial_add_sub_8bit

Overview:
Bit-serial, LSB-first sequential adder/subtractor. It is the area-lean multi-cycle counterpart of the team's combinational 8-bit add/sub datapath.
- Accepts an operand pair and an op select through a valid/ready input handshake.
- Processes one bit per clock through a single full-adder cell.
- Presents the registered result and flags through a valid/ready output handshake.
- Sits between the Tiny Tapeout pin-level operand loader and the result readback logic.

Parameters:
WIDTH, 8, operand/result width in bits (≥2); bit counter is clog2(WIDTH) bits.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/sub presented this cycle
in_ready  out  1  block can accept (high only in IDLE)
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
sub  in  1  0 = A+B, 1 = A−B (two's complement)
out_valid  out  1  result registers hold a completed result (high only in DONE)
out_ready  in  1  consumer takes result
sum  out  WIDTH  result, registered
carry_out  out  1  final carry (sub: 1 = no borrow)
res_zero  out  1  sum == 0
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, internal shift regs/count/carry=0; sum=0, carry_out=0, res_zero=1, out_valid=0, busy=0, in_ready=1.
- States:
  - IDLE: in_ready=1. Handshake on in_valid&in_ready at edge T. Capture A_sr=op_a, B_sr=op_b ^ {WIDTH{sub}}, carry=sub, count=0, then go to RUN.
  - RUN: each edge runs one full-adder step on A_sr[0], B_sr[0], carry.
    - Result bit shifts into the MSB of internal R_sr, right-shifting R_sr; A_sr/B_sr shift right.
    - carry <= cout; count++.
    - On the edge where count==WIDTH-1, go to DONE and load sum <= final R_sr, carry_out <= final cout, res_zero <= (final R_sr == 0).
  - DONE: out_valid=1. On out_ready, go to IDLE; outputs keep their values.
- Latency: result edges T+1..T+WIDTH; out_valid high from the cycle after edge T+WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: with out_ready tied high, one op per WIDTH+2 cycles.
- sum/carry_out/res_zero change only on entry to DONE. They never expose partial results and hold stable through backpressure and the following IDLE/RUN.
- in_valid outside IDLE is ignored; operand inputs need be stable only at the accepting edge.
- DONE with out_ready and in_valid both high: no accept this cycle (in_ready=0); accept possible in the following IDLE cycle.
- out_ready outside DONE: no effect.
- Reset mid-RUN/DONE: operation aborted, all reset values restored immediately; no partial result ever reaches outputs.
- Arithmetic is modulo 2^WIDTH; overflow flag not provided.

Decomposition:
- Shared package/header: state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH.
- Sub-module: one instance of the existing one-bit full adder cell onebitfa for the serial step. Control FSM, counter and shift registers stay in this module.

Test Plan:
1. 0x3C + 0x05, sub=0 → sum=0x41, carry_out=0, res_zero=0; out_valid rises exactly 8 cycles after the accept edge.
2. 0xFF + 0x01, sub=0 → sum=0x00, carry_out=1, res_zero=1. Then 0x10 − 0x10, sub=1 → sum=0x00, carry_out=1, res_zero=1.
3. 0x05 − 0x07, sub=1 → sum=0xFE, carry_out=0, res_zero=0. Then 0x80 − 0x01 → sum=0x7F, carry_out=1.
4. Backpressure: result 0xA5+0x11=0xB6, hold out_ready=0 for 20 cycles while pulsing in_valid with other operands → out_valid, sum=0xB6 and flags stable, in_ready=0, no new op accepted.
5. Assert rst_n=0 during the 4th RUN cycle → outputs immediately sum=0, carry_out=0, res_zero=1, out_valid=0, busy=0. After release, 0x01+0x02 completes correctly as 0x03.
6. Stream 16 random ops with in_valid and out_ready tied high → each accepted every 10 cycles; every result matches the (op_a ± op_b) mod 256 model and its carry/zero flags.
